// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the 4:1 mux select scanner.
package mux_pkg;

  localparam int MUX_CH    = 4;
  localparam int MUX_SEL_W = 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCAN    = 2'd1;
  localparam logic [1:0] PUBLISH = 2'd2;

  // Lowest-numbered channel whose mask bit is clear; 0 when every channel is masked.
  function automatic logic [MUX_SEL_W-1:0] first_unmasked(input logic [MUX_CH-1:0] mask);
    first_unmasked = '0;
    for (int k = MUX_CH - 1; k >= 0; k--) begin
      if (!mask[k]) first_unmasked = MUX_SEL_W'(k);
    end
  endfunction

endpackage

// File: rtl/mux_sel_next.sv
// Next-channel finder for the scanner. Honours a skip mask only when MUX_SCAN_MASK_EN
// is defined; otherwise it simply steps 0..3.
module mux_sel_next
  import mux_pkg::*;
(
  input  logic [MUX_SEL_W-1:0] sel_i,
`ifdef MUX_SCAN_MASK_EN
  input  logic [MUX_CH-1:0]    mask_i,
`endif
  output logic [MUX_SEL_W-1:0] next_o,
  output logic                 last_o
);

`ifdef MUX_SCAN_MASK_EN
  // Scan downward so the lowest unmasked channel above sel_i wins.
  always_comb begin
    next_o = sel_i;
    last_o = 1'b1;
    for (int k = MUX_CH - 1; k >= 0; k--) begin
      if (k > int'(sel_i) && !mask_i[k]) begin
        next_o = MUX_SEL_W'(k);
        last_o = 1'b0;
      end
    end
  end
`else
  assign next_o = sel_i + 1'b1;
  assign last_o = (sel_i == MUX_SEL_W'(MUX_CH - 1));
`endif

endmodule

// File: rtl/mux_sel_scanner.sv
// Drives the 4:1 mux select through its channels, samples m after DWELL cycles each and
// publishes a 4-bit snapshot over valid/ready. Optional skip mask: MUX_SCAN_MASK_EN.
module mux_sel_scanner
  import mux_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 m,
  output logic [MUX_SEL_W-1:0] sel,
  output logic                 busy,
  output logic [MUX_CH-1:0]    snap,
  output logic                 snap_valid,
  input  logic                 snap_ready
`ifdef MUX_SCAN_MASK_EN
  ,
  input  logic [MUX_CH-1:0]    ch_mask
`endif
);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $fatal(1, "mux_sel_scanner: DWELL must be in 1..255");
  end
  if ((DWELL - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $fatal(1, "mux_sel_scanner: CNT_W too narrow for DWELL-1");
  end

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  logic [1:0]           state_q, state_d;
  logic [MUX_SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MUX_CH-1:0]    shadow_q, shadow_d, shadow_upd;
  logic [MUX_CH-1:0]    snap_q, snap_d;
  logic                 cont_q, cont_d;
  logic [MUX_CH-1:0]    scan_mask, launch_mask;
  logic                 launch;
  logic [MUX_SEL_W-1:0] next_sel;
  logic                 last_ch;

`ifdef MUX_SCAN_MASK_EN
  logic [MUX_CH-1:0] mask_q, mask_d;
  assign scan_mask = mask_q;
`else
  assign scan_mask = '0;
`endif

  mux_sel_next u_next (
    .sel_i  (sel_q),
`ifdef MUX_SCAN_MASK_EN
    .mask_i (mask_q),
`endif
    .next_o (next_sel),
    .last_o (last_ch)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    snap_d      = snap_q;
    cont_d      = cont_q;
    launch      = 1'b0;
    launch_mask = scan_mask;
`ifdef MUX_SCAN_MASK_EN
    mask_d      = mask_q;
`endif
    shadow_upd         = shadow_q;
    shadow_upd[sel_q]  = m;

    case (state_q)
      IDLE: begin
        if (start) begin
          launch = 1'b1;
          cont_d = continuous;
`ifdef MUX_SCAN_MASK_EN
          launch_mask = ch_mask;
`endif
        end
      end
      SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          shadow_d = shadow_upd;
          cnt_d    = '0;
          if (last_ch) begin
            state_d = PUBLISH;
            snap_d  = shadow_upd;
          end else begin
            sel_d = next_sel;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PUBLISH: begin
        if (snap_ready) begin
          if (cont_q) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    // A fresh scan starts clean; an all-masked scan publishes zero straight away.
    if (launch) begin
      cnt_d    = '0;
      shadow_d = '0;
`ifdef MUX_SCAN_MASK_EN
      mask_d   = launch_mask;
`endif
      if (&launch_mask) begin
        state_d = PUBLISH;
        sel_d   = '0;
        snap_d  = '0;
      end else begin
        state_d = SCAN;
        sel_d   = first_unmasked(launch_mask);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      snap_q   <= '0;
      cont_q   <= 1'b0;
`ifdef MUX_SCAN_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      cont_q   <= cont_d;
`ifdef MUX_SCAN_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  assign sel        = sel_q;
  assign snap       = snap_q;
  assign busy       = (state_q != IDLE);
  assign snap_valid = (state_q == PUBLISH);

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner; a behavioural 4:1 mux feeds m from the x inputs.
module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst_n, start, continuous, snap_ready, m, busy, snap_valid;
  logic [1:0] sel;
  logic [3:0] snap, x;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;
  assign m = x[sel];

  mux_sel_scanner #(.DWELL(2), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .m          (m),
    .sel        (sel),
    .busy       (busy),
    .snap       (snap),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready)
`ifdef MUX_SCAN_MASK_EN
    ,
    .ch_mask    (4'b0000)
`endif
  );

`ifdef MUX_SCAN_MASK_EN
  logic       m_start, m_ready, m_m, m_busy, m_valid;
  logic [1:0] m_sel;
  logic [3:0] m_snap, m_x, m_mask;
  assign m_m = m_x[m_sel];

  mux_sel_scanner #(.DWELL(3), .CNT_W(8)) u_dut_mask (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (m_start),
    .continuous (1'b0),
    .m          (m_m),
    .sel        (m_sel),
    .busy       (m_busy),
    .snap       (m_snap),
    .snap_valid (m_valid),
    .snap_ready (m_ready),
    .ch_mask    (m_mask)
  );
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Observed vector is {busy, snap_valid, sel, snap}.
  task automatic test_reset;
    logic [7:0] obs;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; snap_ready = 1'b0; x = 4'b0000;
`ifdef MUX_SCAN_MASK_EN
    m_start = 1'b0; m_ready = 1'b0; m_x = 4'b0000; m_mask = 4'b0000;
`endif
    #2;
    tick; tick;
    obs = {busy, snap_valid, sel, snap};
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 8'h00);
    end
    rst_n = 1'b1;
    tick; tick;
    obs = {busy, snap_valid, sel, snap};
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=%b", obs, 8'h00);
    end
  endtask

  task automatic test_basic;
    logic [7:0] obs, exp;
    x = 4'b1011; snap_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8)       exp = {1'b1, 1'b0, 2'((c - 1) / 2), 4'b0000};
      else if (c == 9)  exp = {1'b1, 1'b1, 2'd3, 4'b1011};
      else              exp = {1'b0, 1'b0, 2'd0, 4'b1011};
      obs = {busy, snap_valid, sel, snap};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c < 10) tick;
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] obs, exp;
    x = 4'b1011; snap_ready = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c >= 9 && c <= 13) begin
        x = 4'(c * 5);
        start = 1'b1;
      end else begin
        x = 4'b1011;
        start = 1'b0;
      end
      snap_ready = (c == 14);
      if (c <= 8)       exp = {1'b1, 1'b0, 2'((c - 1) / 2), 4'b1011};
      else if (c <= 14) exp = {1'b1, 1'b1, 2'd3, 4'b1011};
      else              exp = {1'b0, 1'b0, 2'd0, 4'b1011};
      obs = {busy, snap_valid, sel, snap};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c < 16) tick;
    end
    start = 1'b0;
  endtask

  task automatic test_continuous;
    logic [7:0] obs, exp;
    x = 4'b1011; snap_ready = 1'b1; continuous = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; continuous = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      start = (c == 3 || c == 5 || c == 12);
      if (c <= 8)       exp = {1'b1, 1'b0, 2'((c - 1) / 2), 4'b1011};
      else if (c == 9)  exp = {1'b1, 1'b1, 2'd3, 4'b1011};
      else if (c <= 17) exp = {1'b1, 1'b0, 2'((c - 10) / 2), 4'b1011};
      else              exp = {1'b1, 1'b1, 2'd3, 4'b0110};
      obs = {busy, snap_valid, sel, snap};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL continuous cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c == 9)  x = 4'b0110;
      if (c == 18) snap_ready = 1'b0;
      if (c < 19) tick;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] obs, exp;
    // The handshake restarts the latched continuous scan; cycle 1 follows the edge.
    snap_ready = 1'b1;
    tick; tick; tick; tick;
    obs = {busy, snap_valid, sel, snap};
    exp = {1'b1, 1'b0, 2'd1, 4'b0110};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL midscan_pre cyc=4 got=%b exp=%b", obs, exp);
    end
    rst_n = 1'b0;
    #1;
    obs = {busy, snap_valid, sel, snap};
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL midscan_reset got=%b exp=%b", obs, 8'h00);
    end
    tick;
    rst_n = 1'b1;
    x = 4'b0101; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8)       exp = {1'b1, 1'b0, 2'((c - 1) / 2), 4'b0000};
      else if (c == 9)  exp = {1'b1, 1'b1, 2'd3, 4'b0101};
      else              exp = {1'b0, 1'b0, 2'd0, 4'b0101};
      obs = {busy, snap_valid, sel, snap};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c < 10) tick;
    end
  endtask

`ifdef MUX_SCAN_MASK_EN
  task automatic test_mask;
    logic [7:0] obs, exp;
    m_x = 4'b1111; m_mask = 4'b0101; m_ready = 1'b1; m_start = 1'b1;
    tick;
    m_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 3)      exp = {1'b1, 1'b0, 2'd1, 4'b0000};
      else if (c <= 6) exp = {1'b1, 1'b0, 2'd3, 4'b0000};
      else if (c == 7) exp = {1'b1, 1'b1, 2'd3, 4'b1010};
      else             exp = {1'b0, 1'b0, 2'd0, 4'b1010};
      obs = {m_busy, m_valid, m_sel, m_snap};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL mask_0101 cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c < 8) tick;
    end
    m_mask = 4'b1111; m_start = 1'b1;
    tick;
    m_start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      exp = (c == 1) ? {1'b1, 1'b1, 2'd0, 4'b0000} : 8'h00;
      obs = {m_busy, m_valid, m_sel, m_snap};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL mask_all cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c < 2) tick;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_continuous;
    test_reset_mid;
`ifdef MUX_SCAN_MASK_EN
    test_mask;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_sel_scanner.md
# mux_sel_scanner

Sequencer that sits directly upstream of the 4:1 `mux`. It drives the mux `sel` input through channels 0..3, lets the mux output settle for a programmable dwell, and samples `m` for each channel. It then publishes the four samples as one 4-bit snapshot over a valid/ready handshake. It turns the combinational mux into a scanned input port for downstream consumers.

## Interface
- `DWELL`, default 2: cycles each `sel` value is held; `m` is sampled on the last of them; legal range 1..255.
- `CNT_W`, default 8: dwell counter width; must hold `DWELL-1`.

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin one scan; ignored unless idle.
- `continuous`  in  1: sampled at `start`; when 1, rescan immediately after each handshake.
- `m`  in  1: output of the downstream mux.
- `sel`  out  2: mux channel select.
- `busy`  out  1: high whenever not IDLE.
- `snap`  out  4: bit k = sample of channel k.
- `snap_valid`  out  1: snapshot available.
- `snap_ready`  in  1: consumer accepts the snapshot.
- `ch_mask`  in  4: present only with `MUX_SCAN_MASK_EN`; 1 = skip the channel.

## Operation
- Reset values: `sel`=0, `busy`=0, `snap`=0, `snap_valid`=0; state IDLE; counter 0; shadow register 0; continuous flag 0.
- FSM states:
  - IDLE: `start`=1 → SCAN, with `sel`=0 (or the first unmasked channel), counter 0, `continuous` latched.
  - SCAN:
    - Counter counts 0..DWELL-1 with `sel` held.
    - On the edge where counter==DWELL-1, `m` is captured into shadow bit `sel`.
    - If `sel` is the last channel to scan, go to PUBLISH and copy shadow → `snap`.
    - Otherwise go to the next channel and reset the counter.
  - PUBLISH: `snap_valid`=1 and `sel` held at its last value.
    - On `snap_valid && snap_ready`: if the latched continuous flag is 1, go to SCAN with `sel`=first channel; else go to IDLE with `sel`=0.
- `snap` changes only on entry to PUBLISH. It is stable while `snap_valid && !snap_ready`.
- `start` during SCAN or PUBLISH is ignored and has no queued effect.
- Deasserting `continuous` mid-scan has no effect; only the value latched at `start` counts.
- Async reset in any state returns all outputs to their reset values immediately. A partial scan is discarded.
- `DWELL` < 1 is a fatal elaboration error.

## Timing
- Cycle 0 = edge where `start`=1 is seen in IDLE.
- Channel k occupies cycles 1+k·DWELL .. (k+1)·DWELL. `m` is sampled at the end of cycle (k+1)·DWELL.
- `snap_valid` rises at cycle 4·DWELL+1; for DWELL=2 that is cycle 9.
- `busy` rises at cycle 1.
- `snap_valid` falls the cycle after the handshake edge.
- Continuous mode: `sel`=0 on the cycle after the handshake, with no idle gap.
- `snap_ready` held high in PUBLISH gives exactly one-cycle valid.
- Combinational paths: none from inputs to outputs. All outputs are registered.

## Configuration
- `MUX_SCAN_MASK_EN` defined:
  - `ch_mask` port exists and is sampled at `start`.
  - Masked channels are skipped with no dwell cycles; their `snap` bits are 0.
  - Scan latency = (unmasked count)·DWELL.
  - All-masked: PUBLISH is reached at cycle 1 with `snap`=0.
- Not defined: no `ch_mask` port; all four channels are always scanned.

## Structure
- Package `mux_pkg` holds:
  - channel-count constant `MUX_CH=4`;
  - select width `MUX_SEL_W=2`;
  - FSM state encoding IDLE=2'd0, SCAN=2'd1, PUBLISH=2'd2.
- Sub-module `mux_sel_next`: combinational next-channel finder (current `sel` plus mask → next unmasked channel and a last-flag). It is trivial when the macro is off.
- The scanner itself contains the FSM, dwell counter, shadow register and handshake.

## Test plan
- DWELL=2; mux inputs x0..x3=1,1,0,1; pulse `start`; `snap_ready`=1 → `sel` sequence 0,0,1,1,2,2,3,3; `snap`=4'b1011 with `snap_valid` high at cycle 9 for one cycle; `busy` low at cycle 10.
- Back-pressure: `snap_ready`=0 for 5 cycles in PUBLISH while x inputs change → `snap` stays 4'b1011 and `sel` stays 3; the handshake at cycle 14 takes the block to IDLE.
- `continuous`=1 with x changed to 0,1,1,0 before the second scan → second snapshot 4'b0110; `sel`=0 the cycle after the first handshake; `start` pulses during the scan are ignored.
- Reset asserted at cycle 4 of a scan → all outputs 0 immediately; after release, a new `start` produces the full 9-cycle latency.
- With `MUX_SCAN_MASK_EN`: `ch_mask`=4'b0101, DWELL=3, x=1,1,1,1 → `sel` visits only 1 and 3; `snap`=4'b1010 valid at cycle 7. `ch_mask`=4'b1111 → `snap`=0 valid at cycle 1.
